sd_bd_queue: RTL and testbench
==============================

# sd_bd_queue

Buffer-descriptor queue between the host bus and the SD data master. The host writes descriptors (system address word(s), then block-argument word(s)) into an internal RAM; the data master fetches them word by word over a request/acknowledge port and retires each one with a completion pulse. Two instances are used, one for TX descriptors and one for RX descriptors. Each instance reports its free-slot count, and the data master starts a transfer when that count is not equal to BD_NUM.

## Interface
Parameters:
- MEM_WIDTH, 32: RAM word width. Legal values are 32 and 16.
- BD_NUM, 16: descriptor capacity. Must be a power of two.
- WPB, 64/MEM_WIDTH: words per descriptor. Value is 2 (32-bit) or 4 (16-bit).
- BD_WIDTH, clog2(BD_NUM)+1: width of the count outputs.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-low.
- clr, in, 1: synchronous flush.
- we_m, in, 1: host write request.
- dat_in_m, in, MEM_WIDTH: host write data.
- ack_o_m, out, 1: host write acknowledge, 1-cycle pulse.
- re_s, in, 1: master fetch request.
- dat_out_s, out, MEM_WIDTH: fetched word. Valid only while ack_o_s=1.
- ack_o_s, out, 1: fetch acknowledge, 1-cycle pulse per word.
- a_cmp, in, 1: completion pulse; retires the oldest fetched descriptor.
- free_bd, out, BD_WIDTH: free descriptor slots.
- pending_bd, out, BD_WIDTH: descriptors written but not yet fetched.
- wr_ovf, out, 1: sticky flag; write attempted while full.
- cmp_err, out, 1: sticky flag; a_cmp received with nothing outstanding.
- status_clr, in, 1: synchronous clear of both sticky flags.

## Operation
Reset values (rst=0):
- All pointers, counters and ack outputs are 0.
- free_bd=BD_NUM, pending_bd=0, wr_ovf=0, cmp_err=0, dat_out_s=0.
- Read FSM is in R_IDLE.

clr has the same effect as reset, applied synchronously. It overrides every other input in that cycle.

Write side:
- Word index wcnt runs 0..WPB-1. The write pointer wraps modulo BD_NUM*WPB.
- A word is accepted when we_m=1 and ack_o_m=0. The host holds we_m until it sees ack.
- At wcnt=0 with free_bd=0: the word is dropped, ack_o_m is still given, wr_ovf is set, and wcnt stays at 0.
- On acceptance of word WPB-1: free_bd decrements by 1, pending_bd increments by 1, and wcnt returns to 0.
- A partially written descriptor is invisible to the fetch side.

Read FSM states: R_IDLE, R_RD, R_ACK, R_DONE.
- R_IDLE → R_RD when re_s=1 and pending_bd>0. The read address is registered at this transition.
- R_RD → R_ACK, unconditionally; this covers the RAM's one-cycle latency.
- R_ACK drives ack_o_s=1 and dat_out_s=word, and increments the read pointer.
  - If this was not the last word, go to R_RD.
  - If it was the last word, pending_bd decrements and the FSM goes to R_DONE.
- R_DONE → R_IDLE when re_s=0.
- Once word 0 has been acknowledged, all WPB words are delivered regardless of re_s. The master may drop re_s early.
- re_s=1 with pending_bd=0: the FSM stays in R_IDLE and no ack is given.

Completion and count rules:
- a_cmp with free_bd+pending_bd=BD_NUM is ignored and sets cmp_err.
- Otherwise a_cmp increments free_bd.
- Descriptor write-complete and a_cmp in the same cycle: free_bd is unchanged.
- Invariant: free_bd + pending_bd ≤ BD_NUM.
- status_clr clears wr_ovf and cmp_err. If a new error event occurs in the same cycle, that flag is set instead.

## Timing
- Write: we_m sampled high at edge T gives ack_o_m=1 in cycle T+1. The RAM is written at the same edge T.
  - Throughput is at most one word per 2 cycles.
  - free_bd and pending_bd show the update in cycle T+1 after the last word.
- Fetch: re_s sampled high at edge T (with pending_bd>0) gives word 0 acked in cycle T+2, word 1 in T+4, word k in T+2+2k.
- R_DONE lasts at least one cycle, so back-to-back fetches are separated by ≥1 idle cycle.
- Read-after-write: a descriptor completed with ack in cycle T is fetchable by re_s sampled at edge T+1.
- a_cmp changes free_bd in the next cycle.

## Structure
- Shared definitions (existing SD defines include) contain:
  - the MEM_WIDTH selection (RAM_MEM_WIDTH_32 / _16);
  - BD_NUM, WPB, BD_WIDTH;
  - the read FSM state encodings (one-hot, 4 bits).
- Sub-module sd_bd_ram: simple dual-port RAM, BD_NUM*WPB × MEM_WIDTH.
  - Synchronous write, registered-address read, one-cycle latency.
- Top level contains the write logic, the read FSM, the counters and the flags.

## Test plan
- Reset, then write 2 words 0x1000_0000 and 0x0000_0200 (32-bit). Required: ack_o_m after each word; free_bd 16→15; pending_bd=1.
- Hold re_s high. Required: ack_o_s pulses at T+2 and T+4 with data 0x1000_0000, then 0x0000_0200; pending_bd=0. Then drop re_s and send a_cmp. Required: free_bd=16.
- Fill 16 descriptors, then write a 17th first word. Required: ack given, word dropped, wr_ovf=1, free_bd=0. Then status_clr. Required: wr_ovf=0.
- Descriptor write-complete coincident with a_cmp. Required: free_bd unchanged. a_cmp with nothing outstanding. Required: cmp_err=1 and counts unchanged.
- MEM_WIDTH=16, re_s dropped after the ack of word 2. Required: word 3 still acked; FSM reaches R_IDLE.
- Wrap-around and reset:
  - Write, fetch and retire 20 descriptors in sequence. Required: data correct across the pointer wrap.
  - Assert rst in mid-fetch (in R_RD). Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/sd_bd_queue_pkg.sv
// rtl/sd_bd_queue_pkg.sv - shared widths, defaults and read FSM encodings for the BD queue
package sd_bd_queue_pkg;

  localparam int MEM_WIDTH_DEF = 32;
  localparam int BD_NUM_DEF    = 16;
  localparam int BD_WIDTH_DEF  = $clog2(BD_NUM_DEF) + 1;

  typedef logic [3:0] rd_state_t;

  // One-hot read FSM encodings.
  localparam rd_state_t R_IDLE = 4'b0001;
  localparam rd_state_t R_RD   = 4'b0010;
  localparam rd_state_t R_ACK  = 4'b0100;
  localparam rd_state_t R_DONE = 4'b1000;

  // A descriptor is 64 bits: one address word plus one argument word at 32 bits.
  function automatic int words_per_bd(input int mem_width);
    return 64 / mem_width;
  endfunction

endpackage

// File: rtl/sd_bd_queue_if.sv
// rtl/sd_bd_queue_if.sv - host/data-master side signals of one BD queue instance
interface sd_bd_queue_if
  import sd_bd_queue_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int BD_WIDTH  = BD_WIDTH_DEF
);
  logic                 clr;
  logic                 we_m;
  logic [MEM_WIDTH-1:0] dat_in_m;
  logic                 ack_o_m;
  logic                 re_s;
  logic [MEM_WIDTH-1:0] dat_out_s;
  logic                 ack_o_s;
  logic                 a_cmp;
  logic [BD_WIDTH-1:0]  free_bd;
  logic [BD_WIDTH-1:0]  pending_bd;
  logic                 wr_ovf;
  logic                 cmp_err;
  logic                 status_clr;

  modport master (
    output clr, we_m, dat_in_m, re_s, a_cmp, status_clr,
    input  ack_o_m, dat_out_s, ack_o_s, free_bd, pending_bd, wr_ovf, cmp_err
  );

  modport slave (
    input  clr, we_m, dat_in_m, re_s, a_cmp, status_clr,
    output ack_o_m, dat_out_s, ack_o_s, free_bd, pending_bd, wr_ovf, cmp_err
  );
endinterface

// File: rtl/sd_bd_ram.sv
// rtl/sd_bd_ram.sv - simple dual-port descriptor RAM, registered read address
module sd_bd_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];
endmodule

// File: rtl/sd_bd_queue.sv
// rtl/sd_bd_queue.sv - buffer-descriptor queue between host writes and data-master fetches
module sd_bd_queue
  import sd_bd_queue_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int BD_NUM    = BD_NUM_DEF,
  parameter int WPB       = words_per_bd(MEM_WIDTH),
  parameter int BD_WIDTH  = $clog2(BD_NUM) + 1
) (
  input  logic           clk,
  input  logic           rst,
  sd_bd_queue_if.slave   bus
);
  localparam int DEPTH = BD_NUM * WPB;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(WPB);
  localparam logic [CW-1:0]       LAST_WORD = CW'(WPB - 1);
  localparam logic [BD_WIDTH-1:0] BD_FULL   = BD_WIDTH'(BD_NUM);

  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        wcnt;
  logic [CW-1:0]        rcnt;
  logic [BD_WIDTH-1:0]  free_q;
  logic [BD_WIDTH-1:0]  pend_q;
  logic                 ack_m_q;
  logic                 wr_ovf_q;
  logic                 cmp_err_q;
  rd_state_t            state;
  rd_state_t            state_nx;
  logic [MEM_WIDTH-1:0] ram_rdata;

  logic wr_take;
  logic wr_drop;
  logic wr_store;
  logic wr_done;
  logic rd_start;
  logic rd_ack;
  logic rd_last;
  logic cmp_idle;
  logic cmp_ok;
  logic cmp_bad;
  logic ram_we;

  // The ack pulse itself blocks a second acceptance of a held we_m.
  assign wr_take  = bus.we_m & ~ack_m_q;
  assign wr_drop  = wr_take & (wcnt == '0) & (free_q == '0);
  assign wr_store = wr_take & ~wr_drop;
  assign wr_done  = wr_store & (wcnt == LAST_WORD);
  assign ram_we   = wr_store & ~bus.clr;

  assign rd_start = (state == R_IDLE) & bus.re_s & (pend_q != '0);
  assign rd_ack   = (state == R_ACK);
  assign rd_last  = rd_ack & (rcnt == LAST_WORD);

  // Nothing outstanding when every slot is either free or still waiting to be fetched.
  assign cmp_idle = ({1'b0, free_q} + {1'b0, pend_q}) == {1'b0, BD_FULL};
  assign cmp_ok   = bus.a_cmp & ~cmp_idle;
  assign cmp_bad  = bus.a_cmp & cmp_idle;

  always_comb begin
    state_nx = state;
    case (state)
      R_IDLE:  if (rd_start) state_nx = R_RD;
      R_RD:    state_nx = R_ACK;
      R_ACK:   state_nx = rd_last ? R_DONE : R_RD;
      R_DONE:  if (!bus.re_s) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      free_q    <= BD_FULL;
      pend_q    <= '0;
      ack_m_q   <= 1'b0;
      wr_ovf_q  <= 1'b0;
      cmp_err_q <= 1'b0;
      state     <= R_IDLE;
    end else if (bus.clr) begin
      wptr      <= '0;
      rptr      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      free_q    <= BD_FULL;
      pend_q    <= '0;
      ack_m_q   <= 1'b0;
      wr_ovf_q  <= 1'b0;
      cmp_err_q <= 1'b0;
      state     <= R_IDLE;
    end else begin
      ack_m_q <= wr_take;
      if (wr_store) begin
        wptr <= wptr + AW'(1);
        wcnt <= wr_done ? '0 : wcnt + CW'(1);
      end

      state <= state_nx;
      if (rd_ack) begin
        rptr <= rptr + AW'(1);
        rcnt <= rd_last ? '0 : rcnt + CW'(1);
      end

      case ({wr_done, cmp_ok})
        2'b10:   free_q <= free_q - BD_WIDTH'(1);
        2'b01:   free_q <= free_q + BD_WIDTH'(1);
        default: free_q <= free_q;
      endcase

      case ({wr_done, rd_last})
        2'b10:   pend_q <= pend_q + BD_WIDTH'(1);
        2'b01:   pend_q <= pend_q - BD_WIDTH'(1);
        default: pend_q <= pend_q;
      endcase

      wr_ovf_q  <= wr_drop | (wr_ovf_q & ~bus.status_clr);
      cmp_err_q <= cmp_bad | (cmp_err_q & ~bus.status_clr);
    end
  end

  sd_bd_ram #(
    .DW    (MEM_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (bus.dat_in_m),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  assign bus.ack_o_m    = ack_m_q;
  assign bus.ack_o_s    = rd_ack;
  assign bus.dat_out_s  = rd_ack ? ram_rdata : '0;
  assign bus.free_bd    = free_q;
  assign bus.pending_bd = pend_q;
  assign bus.wr_ovf     = wr_ovf_q;
  assign bus.cmp_err    = cmp_err_q;
endmodule

// File: tb/tb_sd_bd_queue.sv
// tb/tb_sd_bd_queue.sv - directed vector table plus corner sequences for sd_bd_queue
module tb_sd_bd_queue;

  typedef struct {
    logic        we;
    logic [31:0] din;
    logic        re;
    logic        cmp;
    logic        sclr;
    logic        clr;
    logic        x_ack_m;
    logic        x_ack_s;
    logic [31:0] x_dout;
    logic [4:0]  x_free;
    logic [4:0]  x_pend;
    logic        x_ovf;
    logic        x_cerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  sd_bd_queue_if #(.MEM_WIDTH(32), .BD_WIDTH(5)) i32 ();
  sd_bd_queue_if #(.MEM_WIDTH(16), .BD_WIDTH(3)) i16 ();

  sd_bd_queue #(.MEM_WIDTH(32), .BD_NUM(16)) u32 (.clk(clk), .rst(rst), .bus(i32));
  sd_bd_queue #(.MEM_WIDTH(16), .BD_NUM(4))  u16 (.clk(clk), .rst(rst), .bus(i16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int we, input logic [31:0] din, input int re, input int cmp,
                              input int sclr, input int clr, input int am, input int as,
                              input logic [31:0] dout, input int fr, input int pd,
                              input int ov, input int ce);
    vec_t v;
    v.we = we[0]; v.din = din; v.re = re[0]; v.cmp = cmp[0]; v.sclr = sclr[0]; v.clr = clr[0];
    v.x_ack_m = am[0]; v.x_ack_s = as[0]; v.x_dout = dout;
    v.x_free = 5'(fr); v.x_pend = 5'(pd); v.x_ovf = ov[0]; v.x_cerr = ce[0];
    return v;
  endfunction

  task automatic write_word32(input logic [31:0] d);
    i32.we_m = 1'b1;
    i32.dat_in_m = d;
    tick();
    chk("w32.ack_o_m", 32'(i32.ack_o_m), 32'd1);
    i32.we_m = 1'b0;
    tick();
  endtask

  task automatic write_word16(input logic [15:0] d);
    i16.we_m = 1'b1;
    i16.dat_in_m = d;
    tick();
    chk("w16.ack_o_m", 32'(i16.ack_o_m), 32'd1);
    i16.we_m = 1'b0;
    tick();
  endtask

  // Fetch one 32-bit descriptor from IDLE with fixed latency, then retire it.
  task automatic fetch32(input logic [31:0] w0, input logic [31:0] w1);
    i32.re_s = 1'b1;
    tick();
    chk("f32.rd.ack_o_s", 32'(i32.ack_o_s), 32'd0);
    tick();
    chk("f32.w0.ack_o_s", 32'(i32.ack_o_s), 32'd1);
    chk("f32.w0.dat", i32.dat_out_s, w0);
    tick();
    tick();
    chk("f32.w1.ack_o_s", 32'(i32.ack_o_s), 32'd1);
    chk("f32.w1.dat", i32.dat_out_s, w1);
    i32.re_s = 1'b0;
    tick();
    i32.a_cmp = 1'b1;
    tick();
    i32.a_cmp = 1'b0;
  endtask

  initial begin
    i32.clr = 0; i32.we_m = 0; i32.dat_in_m = '0; i32.re_s = 0; i32.a_cmp = 0; i32.status_clr = 0;
    i16.clr = 0; i16.we_m = 0; i16.dat_in_m = '0; i16.re_s = 0; i16.a_cmp = 0; i16.status_clr = 0;

    //        we din           re cmp sclr clr | am as dout          free pend ovf cerr
    vt.push_back(mk(1, 32'h1000_0000, 0, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(1, 32'h0000_0200, 0, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  1, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 1, 32'h1000_0000, 15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 1, 32'h0000_0200, 15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 1, 0, 0,  0, 0, 32'h0,         15, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 1, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 1, 0,  0, 0, 32'h0,         16, 0, 0, 1));
    vt.push_back(mk(1, 32'hA000_0000, 1, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  1, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(1, 32'h0000_0A01, 1, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  1, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 1, 32'hA000_0000, 15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 0,  0, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 0, 0, 0,  0, 1, 32'h0000_0A01, 15, 1, 0, 0));
    vt.push_back(mk(1, 32'hB000_0000, 0, 0, 0, 0,  0, 0, 32'h0,         15, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 0, 0, 0,  1, 0, 32'h0,         15, 0, 0, 0));
    vt.push_back(mk(1, 32'h0000_0B01, 0, 1, 0, 0,  0, 0, 32'h0,         15, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         1, 0, 0, 1,  1, 0, 32'h0,         15, 1, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));
    vt.push_back(mk(0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,         16, 0, 0, 0));

    // Reset state of both instances.
    tick(); tick(); tick();
    chk("rst.free32",  32'(i32.free_bd),    32'd16);
    chk("rst.pend32",  32'(i32.pending_bd), 32'd0);
    chk("rst.ack_m32", 32'(i32.ack_o_m),    32'd0);
    chk("rst.ack_s32", 32'(i32.ack_o_s),    32'd0);
    chk("rst.dat32",   i32.dat_out_s,       32'd0);
    chk("rst.flags32", 32'({i32.wr_ovf, i32.cmp_err}), 32'd0);
    chk("rst.free16",  32'(i16.free_bd),    32'd4);
    chk("rst.pend16",  32'(i16.pending_bd), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      chk($sformatf("v%0d.ack_o_m", i),  32'(i32.ack_o_m),    32'(vt[i].x_ack_m));
      chk($sformatf("v%0d.ack_o_s", i),  32'(i32.ack_o_s),    32'(vt[i].x_ack_s));
      chk($sformatf("v%0d.dat_out", i),  i32.dat_out_s,       vt[i].x_dout);
      chk($sformatf("v%0d.free_bd", i),  32'(i32.free_bd),    32'(vt[i].x_free));
      chk($sformatf("v%0d.pending", i),  32'(i32.pending_bd), 32'(vt[i].x_pend));
      chk($sformatf("v%0d.wr_ovf", i),   32'(i32.wr_ovf),     32'(vt[i].x_ovf));
      chk($sformatf("v%0d.cmp_err", i),  32'(i32.cmp_err),    32'(vt[i].x_cerr));
      i32.we_m = vt[i].we;   i32.dat_in_m = vt[i].din; i32.re_s = vt[i].re;
      i32.a_cmp = vt[i].cmp; i32.status_clr = vt[i].sclr; i32.clr = vt[i].clr;
      tick();
    end

    // Fill all 16 slots, then a 17th first word must be acked but dropped.
    for (int i = 0; i < 16; i++) begin
      write_word32(32'hD000_0000 | 32'(i));
      write_word32(32'h0000_0D00 | 32'(i));
    end
    chk("full.free", 32'(i32.free_bd),    32'd0);
    chk("full.pend", 32'(i32.pending_bd), 32'd16);
    write_word32(32'hDEAD_BEEF);
    chk("ovf.wr_ovf", 32'(i32.wr_ovf),  32'd1);
    chk("ovf.free",   32'(i32.free_bd), 32'd0);
    chk("ovf.pend",   32'(i32.pending_bd), 32'd16);
    i32.status_clr = 1'b1;
    tick();
    i32.status_clr = 1'b0;
    chk("sclr.wr_ovf", 32'(i32.wr_ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      fetch32(32'hD000_0000 | 32'(i), 32'h0000_0D00 | 32'(i));
    end
    chk("drain.free", 32'(i32.free_bd),    32'd16);
    chk("drain.pend", 32'(i32.pending_bd), 32'd0);

    // Twenty descriptors through the ring, crossing the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      write_word32(32'h5A00_0000 | 32'(i));
      write_word32(32'h0000_A500 ^ 32'(i));
      fetch32(32'h5A00_0000 | 32'(i), 32'h0000_A500 ^ 32'(i));
    end
    chk("wrap.free", 32'(i32.free_bd), 32'd16);
    chk("wrap.cerr", 32'(i32.cmp_err), 32'd0);

    // 16-bit instance: re_s dropped after word 2, word 3 must still follow.
    write_word16(16'h1234); write_word16(16'h5678); write_word16(16'h9ABC); write_word16(16'hDEF0);
    chk("m16.free", 32'(i16.free_bd),    32'd3);
    chk("m16.pend", 32'(i16.pending_bd), 32'd1);
    i16.re_s = 1'b1;
    tick(); chk("m16.rd0", 32'(i16.ack_o_s), 32'd0);
    tick(); chk("m16.w0", 32'({i16.ack_o_s, i16.dat_out_s}), 32'h1_1234);
    tick(); tick(); chk("m16.w1", 32'({i16.ack_o_s, i16.dat_out_s}), 32'h1_5678);
    tick(); tick(); chk("m16.w2", 32'({i16.ack_o_s, i16.dat_out_s}), 32'h1_9ABC);
    i16.re_s = 1'b0;
    tick(); chk("m16.rd3", 32'(i16.ack_o_s), 32'd0);
    tick(); chk("m16.w3", 32'({i16.ack_o_s, i16.dat_out_s}), 32'h1_DEF0);
    tick(); chk("m16.done.pend", 32'(i16.pending_bd), 32'd0);
    chk("m16.done.ack", 32'(i16.ack_o_s), 32'd0);
    tick();
    write_word16(16'hE000); write_word16(16'hE001); write_word16(16'hE002); write_word16(16'hE003);
    i16.re_s = 1'b1;
    tick(); chk("m16.idle.rd", 32'(i16.ack_o_s), 32'd0);
    tick(); chk("m16.idle.w0", 32'({i16.ack_o_s, i16.dat_out_s}), 32'h1_E000);
    i16.re_s = 1'b0;

    // Asynchronous reset while the 32-bit instance sits in R_RD.
    write_word32(32'hC000_0000);
    write_word32(32'h0000_0C01);
    i32.re_s = 1'b1;
    tick();
    chk("mid.pre.pend", 32'(i32.pending_bd), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid.free",  32'(i32.free_bd),    32'd16);
    chk("mid.pend",  32'(i32.pending_bd), 32'd0);
    chk("mid.ack_s", 32'(i32.ack_o_s),    32'd0);
    chk("mid.dat",   i32.dat_out_s,       32'd0);
    chk("mid.ack_m", 32'(i32.ack_o_m),    32'd0);
    chk("mid.free16", 32'(i16.free_bd),   32'd4);
    i32.re_s = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post.ack_s", 32'(i32.ack_o_s), 32'd0);
    chk("post.free",  32'(i32.free_bd), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
